// File: rtl/syn_sys_mem_arb_pkg.sv
// Shared types and sizing helpers for the sys_mem command-port arbiter.
// Latency: n/a (types only); backpressure: n/a.
package syn_sys_mem_arb_pkg;

    localparam int MAX_NUM_AGENTS = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Agent index width, kept at least 1 so a single-agent build still has a tag bit.
    function automatic int agent_id_w(input int num_agents);
        return (num_agents > 1) ? $clog2(num_agents) : 1;
    endfunction

endpackage

// File: rtl/syn_sys_mem_tag_fifo.sv
// In-order tag FIFO holding the issuing agent of each outstanding read.
// Latency: 1 cycle push-to-visible; backpressure: push ignored while full, pop ignored while empty.
module syn_sys_mem_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             do_push;
    logic             do_pop;

    // Flags are registered, so a pop never makes room for a push in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign cnt_nxt = cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == CNT_W'(DEPTH));
            empty <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/syn_sys_mem_arb.sv
// Round-robin arbiter sharing the sys_mem controller command port; read data is steered back by tag.
// Latency: 1-cycle grant from IDLE, then 1 cmd/cycle; backpressure: cntrlr_wait and a full tag FIFO stall the owner.
module syn_sys_mem_arb
    import syn_sys_mem_arb_pkg::*;
#(
    parameter int NUM_AGENTS    = 2,
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 27,
    parameter int MAX_BURST     = 16,
    parameter int RD_OSTD_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_AGENTS-1:0]        agent_wren,
    input  logic [NUM_AGENTS-1:0]        agent_rden,
    input  logic [NUM_AGENTS*ADDR_W-1:0] agent_addr,
    input  logic [NUM_AGENTS*DATA_W-1:0] agent_wdata,
    output logic [NUM_AGENTS-1:0]        agent_wait,
    output logic [NUM_AGENTS-1:0]        agent_rd_valid,
    output logic [DATA_W-1:0]            agent_rdata,
    input  logic                         cntrlr_wait,
    output logic                         cntrlr_wren,
    output logic                         cntrlr_rden,
    output logic [ADDR_W-1:0]            cntrlr_addr,
    output logic [DATA_W-1:0]            cntrlr_wdata,
    input  logic                         cntrlr_rd_valid,
    input  logic [DATA_W-1:0]            cntrlr_rdata,
    output logic                         rd_underflow_err
);

    localparam int ID_W = agent_id_w(NUM_AGENTS);
    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(MAX_BURST - 1);

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [ID_W-1:0] owner;
    logic [ID_W-1:0] owner_nxt;
    logic [ID_W-1:0] last_owner;
    logic [ID_W-1:0] rr_pick;
    logic [BC_W-1:0] burst_cnt;
    logic            accept;

    logic [NUM_AGENTS-1:0] req;
    logic [NUM_AGENTS-1:0] req_rot;
    logic [ADDR_W-1:0]     addr_arr  [NUM_AGENTS];
    logic [DATA_W-1:0]     wdata_arr [NUM_AGENTS];

    logic            tag_push;
    logic            tag_pop;
    logic            tag_full;
    logic            tag_empty;
    logic [ID_W-1:0] tag_dout;

    assign req = agent_wren | agent_rden;

    always_comb begin
        for (int i = 0; i < NUM_AGENTS; i++) begin
            addr_arr[i]  = agent_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = agent_wdata[i*DATA_W +: DATA_W];
        end
    end

    // Rotate requests so bit 0 is the agent after last_owner; lowest set bit wins.
    assign req_rot = NUM_AGENTS'({req, req} >> (last_owner + ID_W'(1)));

    always_comb begin
        rr_pick = '0;
        for (int i = NUM_AGENTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rr_pick = ID_W'((int'(last_owner) + 1 + i) % NUM_AGENTS);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        cntrlr_wren  = 1'b0;
        cntrlr_rden  = 1'b0;
        cntrlr_addr  = '0;
        cntrlr_wdata = '0;
        agent_wait   = '1;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    owner_nxt = rr_pick;
                end
            end
            GRANT: begin
                cntrlr_wren  = agent_wren[owner];
                cntrlr_rden  = agent_rden[owner] & ~tag_full;
                cntrlr_addr  = addr_arr[owner];
                cntrlr_wdata = wdata_arr[owner];
                accept       = (cntrlr_wren | cntrlr_rden) & ~cntrlr_wait;
                agent_wait[owner] = ~accept;
                // A stalled command keeps req[owner] high, so the grant is held.
                if ((accept && (burst_cnt == BURST_LAST)) || !req[owner]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            owner            <= '0;
            last_owner       <= ID_W'(NUM_AGENTS - 1);
            burst_cnt        <= '0;
            rd_underflow_err <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            if (state == IDLE) begin
                burst_cnt <= '0;
            end else if (accept) begin
                burst_cnt <= burst_cnt + BC_W'(1);
            end
            if ((state == GRANT) && (state_nxt == IDLE)) begin
                last_owner <= owner;
            end
            if (cntrlr_rd_valid && tag_empty) begin
                rd_underflow_err <= 1'b1;
            end
        end
    end

    assign tag_push = cntrlr_rden & ~cntrlr_wait;
    assign tag_pop  = cntrlr_rd_valid & ~tag_empty;

    syn_sys_mem_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (RD_OSTD_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (owner),
        .dout  (tag_dout),
        .full  (tag_full),
        .empty (tag_empty)
    );

    always_comb begin
        agent_rd_valid = '0;
        if (tag_pop) begin
            agent_rd_valid[tag_dout] = 1'b1;
        end
    end

    assign agent_rdata = cntrlr_rdata;

endmodule

// File: tb/tb_syn_sys_mem_arb.sv
// Directed bench for the sys_mem arbiter: grant timing, rotation, tag routing, FIFO-full gating, stalls, underflow.
// Latency: n/a; backpressure: agent drivers hold each command until agent_wait drops.
module tb_syn_sys_mem_arb;

    localparam int NA  = 2;
    localparam int DW  = 32;
    localparam int AW  = 27;
    localparam int MB  = 16;
    localparam int OD  = 8;
    localparam int LAT = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n = 1'b0;
    logic [NA-1:0]    agent_wren = '0;
    logic [NA-1:0]    agent_rden = '0;
    logic [NA*AW-1:0] agent_addr = '0;
    logic [NA*DW-1:0] agent_wdata = '0;
    logic [NA-1:0]    agent_wait;
    logic [NA-1:0]    agent_rd_valid;
    logic [DW-1:0]    agent_rdata;
    logic             cntrlr_wait = 1'b0;
    logic             cntrlr_wren;
    logic             cntrlr_rden;
    logic [AW-1:0]    cntrlr_addr;
    logic [DW-1:0]    cntrlr_wdata;
    logic             cntrlr_rd_valid;
    logic [DW-1:0]    cntrlr_rdata;
    logic             rd_underflow_err;

    syn_sys_mem_arb #(
        .NUM_AGENTS    (NA),
        .DATA_W        (DW),
        .ADDR_W        (AW),
        .MAX_BURST     (MB),
        .RD_OSTD_DEPTH (OD)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .agent_wren       (agent_wren),
        .agent_rden       (agent_rden),
        .agent_addr       (agent_addr),
        .agent_wdata      (agent_wdata),
        .agent_wait       (agent_wait),
        .agent_rd_valid   (agent_rd_valid),
        .agent_rdata      (agent_rdata),
        .cntrlr_wait      (cntrlr_wait),
        .cntrlr_wren      (cntrlr_wren),
        .cntrlr_rden      (cntrlr_rden),
        .cntrlr_addr      (cntrlr_addr),
        .cntrlr_wdata     (cntrlr_wdata),
        .cntrlr_rd_valid  (cntrlr_rd_valid),
        .cntrlr_rdata     (cntrlr_rdata),
        .rd_underflow_err (rd_underflow_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Agent drivers: each agent issues cmd_left commands at base+seq, holding until accepted.
    int            cmd_left [NA] = '{default: 0};
    int            seq      [NA] = '{default: 0};
    logic [AW-1:0] base     [NA] = '{default: '0};
    bit            is_rd    [NA] = '{default: 1'b0};
    logic [NA-1:0] acc_q = '0;

    initial forever begin
        @(negedge clk);
        acc_q = ~agent_wait;
        @(posedge clk);
        #1;
        for (int a = 0; a < NA; a++) begin
            if (acc_q[a] && cmd_left[a] > 0) begin
                cmd_left[a]--;
                seq[a]++;
            end
            agent_wren[a] = (cmd_left[a] > 0) && !is_rd[a];
            agent_rden[a] = (cmd_left[a] > 0) && is_rd[a];
            agent_addr[a*AW +: AW]  = base[a] + AW'(seq[a]);
            agent_wdata[a*DW +: DW] = 32'hD000_0000 | {5'd0, base[a] + AW'(seq[a])};
        end
    end

    function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
        return 32'hA5A5_0000 ^ {5'd0, a};
    endfunction

    // Controller read model: fixed-latency return of a per-address pattern, plus direct injection.
    bit            mdl_en  = 1'b0;
    logic          mdl_vld = 1'b0;
    logic [DW-1:0] mdl_dat = '0;
    bit            pv [LAT] = '{default: 1'b0};
    logic [DW-1:0] pd [LAT] = '{default: '0};
    logic          inj_vld = 1'b0;
    logic [DW-1:0] inj_dat = '0;
    bit            cap_v;
    logic [AW-1:0] cap_a;

    assign cntrlr_rd_valid = mdl_vld | inj_vld;
    assign cntrlr_rdata    = inj_vld ? inj_dat : mdl_dat;

    initial forever begin
        @(negedge clk);
        cap_v = mdl_en && cntrlr_rden && !cntrlr_wait;
        cap_a = cntrlr_addr;
        @(posedge clk);
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0]   = cap_v;
        pd[0]   = rd_pat(cap_a);
        mdl_vld = pv[LAT-1];
        mdl_dat = pd[LAT-1];
    end

    logic [AW-1:0] acc_log [$];

    initial forever begin
        @(negedge clk);
        if (rst_n && (cntrlr_wren || cntrlr_rden) && !cntrlr_wait) begin
            acc_log.push_back(cntrlr_addr);
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [NA-1:0] exp_rv   [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    logic [AW-1:0] exp_ra   [5] = '{27'h300, 27'h301, 27'h302, 27'h400, 27'h401};
    logic [AW-1:0] exp_t5   [7] = '{27'h500, 27'h501, 27'h502, 27'h503, 27'h504, 27'h505, 27'h600};
    logic [NA-1:0] rv_obs   [5];
    logic [DW-1:0] rd_obs   [5];

    initial begin
        int got;
        int exp_ag;
        bit found;

        do_reset(3);
        @(negedge clk);
        check("rst_wait", agent_wait, 2'b11);
        check("rst_wren", cntrlr_wren, 1'b0);
        check("rst_rden", cntrlr_rden, 1'b0);
        check("rst_rdvld", agent_rd_valid, 2'b00);
        check("rst_err", rd_underflow_err, 1'b0);

        // Single agent, 4 writes at 0x10..0x13.
        base[0] = 27'h10; seq[0] = 0; is_rd[0] = 1'b0; cmd_left[0] = 4;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t1_wait", agent_wait, (c >= 1 && c <= 4) ? 2'b10 : 2'b11);
            check("t1_wren", cntrlr_wren, (c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) begin
                check("t1_addr", cntrlr_addr, 27'h10 + AW'(c - 1));
            end
            if (c == 1) begin
                check("t1_wdata", cntrlr_wdata, 32'hD000_0010);
            end
        end

        // Both agents stream writes: 16 for agent0, one idle cycle, 16 for agent1, back to agent0.
        do_reset(1);
        @(negedge clk);
        base[0] = 27'h100; base[1] = 27'h200;
        seq[0] = 0; seq[1] = 0;
        is_rd[0] = 1'b0; is_rd[1] = 1'b0;
        cmd_left[0] = 1000; cmd_left[1] = 1000;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (c == 0 || c == 17 || c == 34) exp_ag = -1;
            else if (c >= 18 && c <= 33)      exp_ag = 1;
            else                              exp_ag = 0;
            check("t2_wait", agent_wait, (exp_ag < 0) ? 2'b11 : (exp_ag == 0) ? 2'b10 : 2'b01);
            if (exp_ag == 0) begin
                check("t2_addr0", cntrlr_addr, (c == 35) ? 27'h110 : 27'h100 + AW'(c - 1));
            end else if (exp_ag == 1) begin
                check("t2_addr1", cntrlr_addr, 27'h200 + AW'(c - 18));
            end
        end
        cmd_left[0] = 0; cmd_left[1] = 0;
        repeat (3) @(negedge clk);

        // Reads: agent1 x3 then agent0 x2, returned in order with latency.
        mdl_en = 1'b1;
        base[1] = 27'h300; seq[1] = 0; is_rd[1] = 1'b1; cmd_left[1] = 3;
        base[0] = 27'h400; seq[0] = 0; is_rd[0] = 1'b1; cmd_left[0] = 2;
        got = 0;
        for (int c = 0; c < 80 && got < 5; c++) begin
            @(negedge clk);
            if (agent_rd_valid != '0) begin
                rv_obs[got] = agent_rd_valid;
                rd_obs[got] = agent_rdata;
                got++;
            end
        end
        check("t3_count", got, 5);
        for (int i = 0; i < got; i++) begin
            check("t3_rdvld", rv_obs[i], exp_rv[i]);
            check("t3_rdata", rd_obs[i], rd_pat(exp_ra[i]));
        end
        mdl_en = 1'b0;
        repeat (3) @(negedge clk);

        // Tag FIFO fills after 8 reads; one return frees one slot.
        @(posedge clk);
        acc_log.delete();
        @(negedge clk);
        base[0] = 27'h700; seq[0] = 0; is_rd[0] = 1'b1; cmd_left[0] = 10;
        repeat (14) @(negedge clk);
        check("t4_full_wait", agent_wait, 2'b11);
        check("t4_full_rden", cntrlr_rden, 1'b0);
        @(posedge clk);
        check("t4_accepts", acc_log.size(), 8);
        #1;
        inj_vld = 1'b1; inj_dat = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t4_ret_vld", agent_rd_valid, 2'b01);
        check("t4_ret_dat", agent_rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        inj_vld = 1'b0;
        @(negedge clk);
        check("t4_9th_wait", agent_wait, 2'b10);
        check("t4_9th_addr", cntrlr_addr, 27'h708);
        @(negedge clk);
        check("t4_refull", agent_wait, 2'b11);
        cmd_left[0] = 0;

        // Reset drops outstanding tags; then a stall mid-burst with agent1 waiting.
        do_reset(1);
        @(posedge clk);
        acc_log.delete();
        @(negedge clk);
        base[0] = 27'h500; seq[0] = 0; is_rd[0] = 1'b0; cmd_left[0] = 6;
        base[1] = 27'h600; seq[1] = 0; is_rd[1] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (agent_wait[0] == 1'b0 && cntrlr_addr == 27'h501) found = 1'b1;
        end
        check("t5_reach", found, 1'b1);
        cmd_left[1] = 1;
        @(posedge clk);
        #1;
        cntrlr_wait = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("t5_hold_addr", cntrlr_addr, 27'h502);
            check("t5_hold_wren", cntrlr_wren, 1'b1);
            check("t5_hold_wait", agent_wait, 2'b11);
        end
        @(posedge clk);
        #1;
        cntrlr_wait = 1'b0;
        repeat (12) @(negedge clk);
        @(posedge clk);
        check("t5_accepts", acc_log.size(), 7);
        for (int i = 0; i < 7 && i < acc_log.size(); i++) begin
            check("t5_order", acc_log[i], exp_t5[i]);
        end

        // Return with nothing outstanding sets the sticky error; reset clears it.
        #1;
        inj_vld = 1'b1; inj_dat = 32'h1234_5678;
        @(negedge clk);
        check("t6_no_rdvld", agent_rd_valid, 2'b00);
        check("t6_err_pre", rd_underflow_err, 1'b0);
        @(posedge clk);
        #1;
        inj_vld = 1'b0;
        @(negedge clk);
        check("t6_err_set", rd_underflow_err, 1'b1);
        repeat (3) @(negedge clk);
        check("t6_err_hold", rd_underflow_err, 1'b1);
        do_reset(1);
        @(negedge clk);
        check("t6_err_clr", rd_underflow_err, 1'b0);
        check("t6_wait_rst", agent_wait, 2'b11);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/syn_sys_mem_arb.md
Name: syn_sys_mem_arb

Overview:
- Round-robin arbiter that shares the single sys_mem controller command port among NUM_AGENTS requesters inside cortex (e.g. PCM capture writer, FFT/video readers).
- Runs in the controller clock domain.
- Grants one agent at a time, for a bounded burst of commands.
- Routes returning read data to the issuing agent through an in-order tag FIFO.

Parameters:
- NUM_AGENTS, 2, number of requesters (2..8)
- DATA_W, 32, data width
- ADDR_W, 27, address width
- MAX_BURST, 16, maximum commands accepted per grant before forced rotation
- RD_OSTD_DEPTH, 8, maximum outstanding reads (tag FIFO depth, power of 2)

Ports:
- clk  in  1  controller clock (cntrlr_clk domain)
- rst_n  in  1  synchronous, active-low reset
- agent_wren  in  NUM_AGENTS  per-agent write request
- agent_rden  in  NUM_AGENTS  per-agent read request
- agent_addr  in  NUM_AGENTS*ADDR_W  packed addresses, agent i at [i*ADDR_W +: ADDR_W]
- agent_wdata  in  NUM_AGENTS*DATA_W  packed write data
- agent_wait  out  NUM_AGENTS  per-agent stall
- agent_rd_valid  out  NUM_AGENTS  read data valid for agent i
- agent_rdata  out  DATA_W  read data, broadcast to all agents
- cntrlr_wait  in  1  controller stall
- cntrlr_wren  out  1  write to controller
- cntrlr_rden  out  1  read to controller
- cntrlr_addr  out  ADDR_W  controller address
- cntrlr_wdata  out  DATA_W  controller write data
- cntrlr_rd_valid  in  1  controller read data valid
- cntrlr_rdata  in  DATA_W  controller read data
- rd_underflow_err  out  1  sticky error: rd_valid seen with no outstanding tag

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-low on `rst_n`.
- Reset values:
  - state=IDLE, owner=0, last_owner=NUM_AGENTS-1, burst_cnt=0.
  - Tag FIFO empty; rd_underflow_err=0.
  - cntrlr_wren/rden=0; agent_wait=all 1s; agent_rd_valid=0.
- Request: req[i] = agent_wren[i] | agent_rden[i]. Agents must hold a request and its address/data stable until they see agent_wait[i]=0 in the same cycle.
- IDLE state:
  - Controller outputs are driven as wren=rden=0; addr/wdata are don't-care and driven 0.
  - Round-robin search begins at last_owner+1 (mod NUM_AGENTS).
  - If any req is set, register owner=first hit, clear burst_cnt, and move to GRANT.
  - Arbitration costs 1 cycle: the command is first visible to the controller the cycle after the request.
- GRANT state:
  - Controller outputs combinationally mux agent[owner] signals.
  - cntrlr_rden is gated low when the tag FIFO is full.
  - accept = (cntrlr_wren & ~cntrlr_wait) | (cntrlr_rden & ~cntrlr_wait).
  - agent_wait[owner] = ~accept; agent_wait[j≠owner] = 1.
  - On accept: burst_cnt++. An accepted read pushes owner into the tag FIFO.
- GRANT → IDLE (last_owner←owner) when either:
  - accept and burst_cnt==MAX_BURST-1, or
  - req[owner]==0 (owner idle for one cycle, no accept).
- GRANT never releases while a command is presented but stalled.
- Read return:
  - When cntrlr_rd_valid=1 and the FIFO is non-empty: pop, assert agent_rd_valid[tag]=1 in the same cycle, and pass agent_rdata=cntrlr_rdata combinationally.
  - Read return is independent of arbitration state.
- Boundary cases:
  - cntrlr_rd_valid with FIFO empty: no agent_rd_valid; rd_underflow_err set and held until reset.
  - Push and pop in the same cycle: count unchanged.
  - Full: pop and push in the same cycle are both allowed, but the push is enabled only by the registered not-full. There is no read-through.
  - Write while FIFO full: writes are not blocked; only reads are gated.
- Mid-operation reset: all state is cleared and outstanding tags are dropped. rd_valid returns after reset are flagged as underflow errors.
- Latency: 1-cycle grant latency from IDLE, then 1 command per cycle when cntrlr_wait=0.

Decomposition:
- Package syn_sys_mem_arb_pkg:
  - arb_state_t enum {IDLE, GRANT}
  - AGENT_ID_W = $clog2(NUM_AGENTS) helper function
  - MAX_NUM_AGENTS = 8
- Sub-module syn_sys_mem_tag_fifo:
  - Synchronous FIFO, width AGENT_ID_W, depth RD_OSTD_DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Registered full/empty; dout valid whenever ~empty.

Test Plan:
- Single agent: agent0 issues 4 writes to addrs 0x10..0x13 with cntrlr_wait=0 → first cntrlr_wren 1 cycle after request, then 4 consecutive cycles; agent1 wait stays 1.
- Both agents hold continuous writes, MAX_BURST=16 → exactly 16 accepts for agent0, 1 IDLE cycle, 16 for agent1, then back to agent0.
- Agent1 issues 3 reads, agent0 issues 2 reads; controller returns 5 rd_valids with latency 6 → agent_rd_valid pattern 1,1,1 (agent1) then 0,0 (agent0), with rdata matching.
- Agent0 issues 10 back-to-back reads with no returns → after 8 accepts cntrlr_rden=0 and agent_wait[0]=1; one rd_valid → 9th read accepted next cycle.
- cntrlr_wait held high for 5 cycles mid-burst → command held stable on the controller port, burst_cnt unchanged, no rotation even when agent1 requests.
- Inject cntrlr_rd_valid with no outstanding reads → rd_underflow_err=1 and stays 1; rst_n=0 for one clk → clears to 0, agent_wait=all 1s.
